uart_line_cmd: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 33 +++
 rtl/uart_line_buf.sv | 47 ++++
 rtl/uart_line_cmd.sv | 160 ++++++++++++++++
 tb/tb_uart_line_cmd.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART line command block: state encoding,
// control characters and the ASCII hex digit decoder.
package uart_cmd_pkg;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_RECV,
        ST_CHECK,
        ST_ECHO,
        ST_TERMTX,
        ST_CLEAR
    } state_t;

    typedef struct packed {
        logic       ok;
        logic [3:0] nib;
    } hex_nib_t;

    // Map one ASCII character to its hex value; ok=0 for non-hex characters.
    function automatic hex_nib_t hex_to_nibble(input logic [7:0] c);
        hex_nib_t r;
        r.ok  = 1'b1;
        r.nib = 4'h0;
        if (c >= 8'h30 && c <= 8'h39)      r.nib = 4'(c - 8'h30);
        else if (c >= 8'h41 && c <= 8'h46) r.nib = 4'(c - 8'h37);
        else if (c >= 8'h61 && c <= 8'h66) r.nib = 4'(c - 8'h57);
        else                               r.ok  = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/uart_line_buf.sv
// Line storage: DEPTH x 8 bytes with write index, overflow latch,
// a random read port and a parallel view of the leading HEAD bytes.
module uart_line_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned HEAD  = 6,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic              I_clk,
    input  logic              I_rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              clr,
    input  logic [AW-1:0]     rd_addr,
    output logic [7:0]        rd_data,
    output logic [8*HEAD-1:0] head,
    output logic [LW-1:0]     idx,
    output logic              ovf
);

    logic [7:0] mem [DEPTH];

    // Index and overflow latch; bytes past capacity are dropped but remembered.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            idx <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            idx <= '0;
            ovf <= 1'b0;
        end else if (wr_en) begin
            if (idx < LW'(DEPTH)) idx <= idx + LW'(1);
            else                  ovf <= 1'b1;
        end
    end

    always_ff @(posedge I_clk) begin
        if (wr_en && idx < LW'(DEPTH)) mem[idx[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

    always_comb begin
        for (int i = 0; i < int'(HEAD); i++) head[8*i +: 8] = mem[i];
    end

endmodule

// File: rtl/uart_line_cmd.sv
// Line accumulator with optional echo and RRGGBB hex colour command parser,
// sitting between uart_rx/uart_tx and the pixel colour logic.
module uart_line_cmd
    import uart_cmd_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter logic [7:0]  TERM       = LF,
    parameter bit          ECHO_EN    = 1'b1,
    parameter int unsigned HEX_DIGITS = 6,
    localparam int unsigned CW        = 4 * HEX_DIGITS,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned LW        = $clog2(DEPTH) + 1
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    input  logic [7:0]    I_rx_data,
    input  logic          I_rx_valid,
    output logic          O_rx_ready,
    output logic [7:0]    O_tx_data,
    output logic          O_tx_valid,
    input  logic          I_tx_ready,
    output logic [CW-1:0] O_color,
    output logic          O_color_upd,
    output logic          O_err_ovf,
    output logic          O_err_fmt,
    output logic [LW-1:0] O_line_len
);

    state_t                    state, state_n;
    logic [AW-1:0]             send, send_n;
    logic                      rx_ready_n, tx_valid_n, color_upd_n;
    logic                      err_ovf_n, err_fmt_n;
    logic [7:0]                tx_data_n;
    logic [CW-1:0]             color_n, cmd_color;
    logic [LW-1:0]             line_len_n, idx;
    logic                      wr_en, clr, ovf, cmd_ok;
    logic [7:0]                rd_data;
    logic [8*HEX_DIGITS-1:0]   head;
    hex_nib_t                  hn;

    uart_line_buf #(.DEPTH(DEPTH), .HEAD(HEX_DIGITS)) u_buf (
        .I_clk   (I_clk),
        .I_rst_n (I_rst_n),
        .wr_en   (wr_en),
        .wr_data (I_rx_data),
        .clr     (clr),
        .rd_addr (send),
        .rd_data (rd_data),
        .head    (head),
        .idx     (idx),
        .ovf     (ovf)
    );

    // Parse the leading digits; text order R1R0G1G0B1B0 packs as {B,G,R}.
    always_comb begin
        cmd_ok    = !ovf && (idx == LW'(HEX_DIGITS));
        cmd_color = '0;
        hn        = '0;
        for (int i = 0; i < int'(HEX_DIGITS); i++) begin
            hn     = hex_to_nibble(head[8*i +: 8]);
            cmd_ok = cmd_ok & hn.ok;
            if ((i % 2) == 0) cmd_color[8*(i/2)+4 +: 4] = hn.nib;
            else              cmd_color[8*(i/2) +: 4]   = hn.nib;
        end
    end

    always_comb begin
        state_n     = state;
        send_n      = send;
        tx_valid_n  = O_tx_valid;
        tx_data_n   = O_tx_data;
        color_n     = O_color;
        color_upd_n = 1'b0;
        err_ovf_n   = O_err_ovf;
        err_fmt_n   = O_err_fmt;
        line_len_n  = O_line_len;
        wr_en       = 1'b0;
        clr         = 1'b0;
        case (state)
            ST_RECV: begin
                if (I_rx_valid && O_rx_ready) begin
                    if (I_rx_data == TERM)    state_n = ST_CHECK;
                    else if (I_rx_data != CR) wr_en   = 1'b1;
                end
            end
            ST_CHECK: begin
                line_len_n = idx;
                err_ovf_n  = ovf;
                if (cmd_ok) begin
                    color_n     = cmd_color;
                    color_upd_n = 1'b1;
                    err_fmt_n   = 1'b0;
                end else begin
                    err_fmt_n = 1'b1;
                end
                if (ECHO_EN && idx != '0) begin
                    state_n    = ST_ECHO;
                    tx_valid_n = 1'b1;
                    tx_data_n  = rd_data;
                end else begin
                    state_n = ST_CLEAR;
                end
            end
            // After each transfer valid drops; the next byte waits for ready.
            ST_ECHO: begin
                if (O_tx_valid && I_tx_ready) begin
                    tx_valid_n = 1'b0;
                    if (LW'(send) == idx - LW'(1)) state_n = ST_TERMTX;
                    else                           send_n  = send + AW'(1);
                end else if (!O_tx_valid && I_tx_ready) begin
                    tx_valid_n = 1'b1;
                    tx_data_n  = rd_data;
                end
            end
            ST_TERMTX: begin
                if (O_tx_valid && I_tx_ready) begin
                    tx_valid_n = 1'b0;
                    state_n    = ST_CLEAR;
                end else if (!O_tx_valid && I_tx_ready) begin
                    tx_valid_n = 1'b1;
                    tx_data_n  = TERM;
                end
            end
            ST_CLEAR: begin
                clr     = 1'b1;
                send_n  = '0;
                state_n = ST_RECV;
            end
            default: state_n = ST_RECV;
        endcase
        rx_ready_n = (state_n == ST_RECV);
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state       <= ST_RECV;
            send        <= '0;
            O_rx_ready  <= 1'b0;
            O_tx_data   <= '0;
            O_tx_valid  <= 1'b0;
            O_color     <= '0;
            O_color_upd <= 1'b0;
            O_err_ovf   <= 1'b0;
            O_err_fmt   <= 1'b0;
            O_line_len  <= '0;
        end else begin
            state       <= state_n;
            send        <= send_n;
            O_rx_ready  <= rx_ready_n;
            O_tx_data   <= tx_data_n;
            O_tx_valid  <= tx_valid_n;
            O_color     <= color_n;
            O_color_upd <= color_upd_n;
            O_err_ovf   <= err_ovf_n;
            O_err_fmt   <= err_fmt_n;
            O_line_len  <= line_len_n;
        end
    end

endmodule

// File: tb/tb_uart_line_cmd.sv
// Directed self-checking bench for uart_line_cmd (DEPTH=16, TERM=LF, echo on).
module tb_uart_line_cmd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [23:0] color;
    logic        color_upd;
    logic        err_ovf;
    logic        err_fmt;
    logic [4:0]  line_len;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    logic [7:0] tx_q [$];

    uart_line_cmd dut (
        .I_clk       (clk),
        .I_rst_n     (rst_n),
        .I_rx_data   (rx_data),
        .I_rx_valid  (rx_valid),
        .O_rx_ready  (rx_ready),
        .O_tx_data   (tx_data),
        .O_tx_valid  (tx_valid),
        .I_tx_ready  (tx_ready),
        .O_color     (color),
        .O_color_upd (color_upd),
        .O_err_ovf   (err_ovf),
        .O_err_fmt   (err_fmt),
        .O_line_len  (line_len)
    );

    always #5 clk = ~clk;

    // Capture every TX handshake and count colour update pulses.
    always @(posedge clk) begin
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (color_upd) upd_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!rx_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(n < 400), 32'd1);
    endtask

    task automatic check_echo(input string tag, input string exp, input int base);
        int n = 0;
        for (int i = 0; i < exp.len(); i++) begin
            if (exp[i] != 8'h0D) begin
                check($sformatf("%s_tx%0d", tag, n), 32'(tx_q[base+n]), 32'(exp[i]));
                n++;
            end
        end
        check({tag, "_txcnt"}, 32'(tx_q.size() - base), 32'(n));
    endtask

    initial begin
        int base, ubase, k, bad;
        logic [7:0] held;
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_color", 32'(color), 32'd0);
        check("rst_flags", 32'({err_ovf, err_fmt, color_upd}), 32'd0);
        check("rst_len", 32'(line_len), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rx_ready_up", 32'(rx_ready), 32'd1);

        // Valid command with latency probe around CHECK.
        base = tx_q.size(); ubase = upd_cnt;
        send_str("FF8000");
        send_byte(8'h0A);
        check("t1_in_check_upd", 32'(color_upd), 32'd0);
        check("t1_in_check_rdy", 32'(rx_ready), 32'd0);
        @(negedge clk);
        check("t1_upd_pulse", 32'(color_upd), 32'd1);
        check("t1_color_now", 32'(color), 32'h0080FF);
        check("t1_txv_now", 32'(tx_valid), 32'd1);
        wait_idle("t1");
        check("t1_color", 32'(color), 32'h0080FF);
        check("t1_upd_cnt", 32'(upd_cnt - ubase), 32'd1);
        check("t1_fmt", 32'(err_fmt), 32'd0);
        check("t1_ovf", 32'(err_ovf), 32'd0);
        check("t1_len", 32'(line_len), 32'd6);
        check_echo("t1", "FF8000\n", base);

        // Mixed case digits with a CR before the terminator.
        base = tx_q.size(); ubase = upd_cnt;
        send_str("0a0B0c\r\n");
        wait_idle("t2");
        check("t2_color", 32'(color), 32'h0C0B0A);
        check("t2_upd_cnt", 32'(upd_cnt - ubase), 32'd1);
        check("t2_len", 32'(line_len), 32'd6);
        check("t2_fmt", 32'(err_fmt), 32'd0);
        check_echo("t2", "0a0B0c\n", base);

        // Bad hex digit: colour held, no update pulse.
        base = tx_q.size(); ubase = upd_cnt;
        send_str("12345G\n");
        wait_idle("t3");
        check("t3_fmt", 32'(err_fmt), 32'd1);
        check("t3_color", 32'(color), 32'h0C0B0A);
        check("t3_upd_cnt", 32'(upd_cnt - ubase), 32'd0);
        check("t3_len", 32'(line_len), 32'd6);
        check_echo("t3", "12345G\n", base);

        // Overflow: 20 bytes into a 16-byte buffer.
        base = tx_q.size();
        send_str("ABCDEFGHIJKLMNOPQRST\n");
        wait_idle("t4");
        check("t4_ovf", 32'(err_ovf), 32'd1);
        check("t4_fmt", 32'(err_fmt), 32'd1);
        check("t4_len", 32'(line_len), 32'd16);
        check("t4_color", 32'(color), 32'h0C0B0A);
        check_echo("t4", "ABCDEFGHIJKLMNOP\n", base);

        // Empty line: no TX at all.
        base = tx_q.size();
        send_str("\r\n");
        wait_idle("t5");
        check("t5_fmt", 32'(err_fmt), 32'd1);
        check("t5_ovf", 32'(err_ovf), 32'd0);
        check("t5_len", 32'(line_len), 32'd0);
        check("t5_txcnt", 32'(tx_q.size() - base), 32'd0);

        // Stall mid-echo for 50 cycles while injecting RX bytes.
        base = tx_q.size(); ubase = upd_cnt;
        send_str("123456\n");
        k = 0;
        while (!(tx_valid && (tx_q.size() - base) >= 2) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("t6_reach_stall", 32'(k < 200), 32'd1);
        tx_ready = 1'b0;
        held = tx_data;
        k = tx_q.size() - base;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            rx_data  = (c % 2 == 0) ? 8'h0A : 8'h39;
            rx_valid = 1'b1;
            @(negedge clk);
            if (!(tx_valid === 1'b1 && tx_data === held && rx_ready === 1'b0)) bad++;
        end
        rx_valid = 1'b0;
        check("t6_stall_stable", 32'(bad), 32'd0);
        check("t6_held_byte", 32'(held), 32'(8'h31 + 8'(k)));
        tx_ready = 1'b1;
        wait_idle("t6");
        check("t6_color", 32'(color), 32'h563412);
        check("t6_upd_cnt", 32'(upd_cnt - ubase), 32'd1);
        check("t6_len", 32'(line_len), 32'd6);
        check_echo("t6", "123456\n", base);

        // Reset in the middle of an echo, then a fresh command.
        send_str("ABCDEF\n");
        k = 0;
        while (!tx_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("t7_in_echo", 32'(tx_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t7_rst_txv", 32'(tx_valid), 32'd0);
        check("t7_rst_color", 32'(color), 32'd0);
        check("t7_rst_misc", 32'({rx_ready, color_upd, err_ovf, err_fmt, line_len}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        base = tx_q.size(); ubase = upd_cnt;
        send_str("000000\n");
        wait_idle("t7");
        check("t7_upd_cnt", 32'(upd_cnt - ubase), 32'd1);
        check("t7_color", 32'(color), 32'h000000);
        check("t7_fmt", 32'(err_fmt), 32'd0);
        check("t7_len", 32'(line_len), 32'd6);
        check_echo("t7", "000000\n", base);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
